osecpu_dbg_capture: RTL and testbench

- Parametrised successor to the single CPDR debug register in the OSECPU top level.
- Captures integer-register values written by the CPDR instruction (op 8'hD3) into CH per-channel debug registers, tagged with channel and PC.
- Queues each capture in a FIFO that a host/monitor drains over a valid/ready handshake.
- Sits beside Controller/DataPath; fed by instr0, current_state, ireg_d0 and pc.

---
 rtl/osecpu_dbg_capture.sv | 154 +++++++++++++++
 tb/tb_osecpu_dbg_capture.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/osecpu_dbg_capture.sv
// osecpu_dbg_capture: CPDR debug capture registers plus capture FIFO.
// Optional build macro: DBG_CAPTURE_STALL_EN (back-pressure instead of drop).
//
// Ports:
//   clk, reset            clock, asynchronous active-low reset
//   instr_op, cur_state   capture qualifiers (op D3 in state 1)
//   ch_sel, cap_data, pc  capture channel, value and PC tag
//   dr                    CH debug registers, channel k at [k*DATA_W +: DATA_W]
//   out_valid/out_ready   FIFO head handshake
//   out_data/out_ch/out_pc FIFO head fields
//   fifo_count            entries held, 0..DEPTH
//   ovf, ovf_cnt          sticky drop flag, saturating drop counter
//   stall                 full-and-not-draining (0 unless DBG_CAPTURE_STALL_EN)
module osecpu_dbg_capture #(
    parameter int DATA_W = 32,
    parameter int PC_W   = 16,
    parameter int CH     = 4,
    parameter int DEPTH  = 8,
    parameter int CNT_W  = 8,
    localparam int CHW   = $clog2(CH),
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [7:0]           instr_op,
    input  logic [3:0]           cur_state,
    input  logic [CHW-1:0]       ch_sel,
    input  logic [DATA_W-1:0]    cap_data,
    input  logic [PC_W-1:0]      pc,
    output logic [CH*DATA_W-1:0] dr,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DATA_W-1:0]    out_data,
    output logic [CHW-1:0]       out_ch,
    output logic [PC_W-1:0]      out_pc,
    output logic [AW:0]          fifo_count,
    output logic                 ovf,
    output logic [CNT_W-1:0]     ovf_cnt,
    output logic                 stall
);

    localparam logic [7:0]  LP_OP_CPDR = 8'hD3;
    localparam logic [3:0]  LP_ST_EXEC = 4'd1;
    localparam logic [AW:0] LP_FULL    = (AW+1)'(DEPTH);

    logic [DATA_W-1:0] r_dr [CH];

    logic [DATA_W-1:0] r_mem_data [DEPTH];
    logic [CHW-1:0]    r_mem_ch   [DEPTH];
    logic [PC_W-1:0]   r_mem_pc   [DEPTH];

    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [AW:0]       r_count;
    logic              r_ovf;
    logic [CNT_W-1:0]  r_ovf_cnt;

    logic w_cap;
    logic w_full;
    logic w_pop;
    logic w_push;
    logic w_drop;
    logic w_dr_we;
    logic w_stall;

    assign w_cap  = (instr_op == LP_OP_CPDR) && (cur_state == LP_ST_EXEC);
    assign w_full = (r_count == LP_FULL);
    assign w_pop  = out_valid && out_ready;

    // A pop frees the slot in the same cycle, so a full FIFO still
    // accepts a push when the consumer is draining.
    assign w_push = w_cap && (!w_full || w_pop);

`ifdef DBG_CAPTURE_STALL_EN
    // The controller replays the held capture, so the blocked attempt
    // must leave dr untouched to keep dr and the FIFO in step.
    assign w_stall = w_full && !out_ready;
    assign w_drop  = 1'b0;
    assign w_dr_we = w_push;
`else
    assign w_stall = 1'b0;
    assign w_drop  = w_cap && w_full && !w_pop;
    assign w_dr_we = w_cap;
`endif

    assign stall = w_stall;

    // Debug registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < CH; k++) begin
                r_dr[k] <= '0;
            end
        end else if (w_dr_we) begin
            r_dr[ch_sel] <= cap_data;
        end
    end

    for (genvar g = 0; g < CH; g++) begin : g_dr
        assign dr[g*DATA_W +: DATA_W] = r_dr[g];
    end

    // Entry storage needs no reset: only slots behind r_count are read.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_data[r_wr_ptr] <= cap_data;
            r_mem_ch[r_wr_ptr]   <= ch_sel;
            r_mem_pc[r_wr_ptr]   <= pc;
        end
    end

    // Pointers and occupancy
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Overflow tracking
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ovf     <= 1'b0;
            r_ovf_cnt <= '0;
        end else if (w_drop) begin
            r_ovf <= 1'b1;
            if (r_ovf_cnt != '1) begin
                r_ovf_cnt <= r_ovf_cnt + 1'b1;
            end
        end
    end

    assign out_valid  = (r_count != '0);
    assign out_data   = r_mem_data[r_rd_ptr];
    assign out_ch     = r_mem_ch[r_rd_ptr];
    assign out_pc     = r_mem_pc[r_rd_ptr];
    assign fifo_count = r_count;
    assign ovf        = r_ovf;
    assign ovf_cnt    = r_ovf_cnt;

endmodule

// File: tb/tb_osecpu_dbg_capture.sv
// tb_osecpu_dbg_capture: directed bench with expected-entry scoreboard
// for osecpu_dbg_capture (default parameters).
module tb_osecpu_dbg_capture;

    logic        clk;
    logic        reset;
    logic [7:0]  instr_op;
    logic [3:0]  cur_state;
    logic [1:0]  ch_sel;
    logic [31:0] cap_data;
    logic [15:0] pc;
    logic [127:0] dr;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [1:0]  out_ch;
    logic [15:0] out_pc;
    logic [3:0]  fifo_count;
    logic        ovf;
    logic [7:0]  ovf_cnt;
    logic        stall;

    osecpu_dbg_capture dut (
        .clk        (clk),
        .reset      (reset),
        .instr_op   (instr_op),
        .cur_state  (cur_state),
        .ch_sel     (ch_sel),
        .cap_data   (cap_data),
        .pc         (pc),
        .dr         (dr),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_ch     (out_ch),
        .out_pc     (out_pc),
        .fifo_count (fifo_count),
        .ovf        (ovf),
        .ovf_cnt    (ovf_cnt),
        .stall      (stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  ch;
        logic [15:0] pc;
        logic [31:0] d;
    } ent_t;

    ent_t        sb[$];
    logic [31:0] m_dr [4];
    int          m_count;
    int          m_ovf_cnt;
    logic        m_ovf;
    int          n_checks;
    int          n_fail;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        instr_op  = 8'h00;
        cur_state = 4'd0;
        out_ready = 1'b0;
    endtask

    task automatic model_clear();
        sb.delete();
        m_count   = 0;
        m_ovf_cnt = 0;
        m_ovf     = 1'b0;
        for (int k = 0; k < 4; k++) m_dr[k] = '0;
    endtask

    task automatic chk_dr(input string tag);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("%s_dr%0d", tag, k), dr[k*32 +: 32], m_dr[k]);
        end
    endtask

    task automatic chk_head(input string tag);
        ent_t e;
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 64'(out_valid), 64'd0);
        end else begin
            e = sb.pop_front();
            chk({tag, "_valid"}, 64'(out_valid), 64'd1);
            chk({tag, "_data"}, 64'(out_data), 64'(e.d));
            chk({tag, "_ch"}, 64'(out_ch), 64'(e.ch));
            chk({tag, "_pc"}, 64'(out_pc), 64'(e.pc));
        end
    endtask

    task automatic do_reset();
        #1;
        reset = 1'b0;
        model_clear();
        idle();
        step();
        reset = 1'b1;
    endtask

    // One capture cycle, optionally with out_ready asserted alongside.
    task automatic cap(input logic [1:0] ch, input logic [31:0] d,
                       input logic [15:0] p, input logic rdy);
        ent_t e;
        bit   pop;
        bit   acc;
        instr_op  = 8'hD3;
        cur_state = 4'd1;
        ch_sel    = ch;
        cap_data  = d;
        pc        = p;
        out_ready = rdy;
        pop = rdy && (m_count != 0);
        acc = (m_count < 8) || pop;
        if (pop) begin
            chk_head("cap_pop");
            m_count--;
        end
        if (acc) begin
            e.ch = ch;
            e.pc = p;
            e.d  = d;
            sb.push_back(e);
            m_count++;
            m_dr[ch] = d;
        end else begin
            m_dr[ch] = d;
            m_ovf    = 1'b1;
            if (m_ovf_cnt < 255) m_ovf_cnt++;
        end
        step();
        idle();
    endtask

    task automatic pop_one(input string tag);
        chk_head(tag);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        if (m_count > 0) m_count--;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b0;
        ch_sel   = '0;
        cap_data = '0;
        pc       = '0;
        idle();
        model_clear();
        #2;
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_count", 64'(fifo_count), 64'd0);
        chk("rst_ovf", 64'(ovf), 64'd0);
        chk("rst_ovf_cnt", 64'(ovf_cnt), 64'd0);
        chk("rst_stall", 64'(stall), 64'd0);
        chk_dr("rst");
        step();
        reset = 1'b1;
        step();

        // Single capture
        cap(2'd2, 32'hDEADBEEF, 16'h0040, 1'b0);
        chk_dr("single");
        chk("single_count", 64'(fifo_count), 64'd1);
        pop_one("single_head");
        chk("single_drained_count", 64'(fifo_count), 64'd0);
        chk("single_drained_valid", 64'(out_valid), 64'd0);

        // Non-capture combinations
        instr_op  = 8'hD3;
        cur_state = 4'd2;
        cap_data  = 32'h1234;
        step();
        instr_op  = 8'hD2;
        cur_state = 4'd1;
        step();
        idle();
        chk_dr("filter");
        chk("filter_count", 64'(fifo_count), 64'd0);
        chk("filter_ovf", 64'(ovf), 64'd0);

        // out_ready while empty is ignored
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("empty_rdy_count", 64'(fifo_count), 64'd0);

        // Fill, drain, wrap
        for (int i = 1; i <= 8; i++) begin
            cap(2'(i - 1), 32'(i), 16'(16'h0100 + i), 1'b0);
        end
        chk("fill_count", 64'(fifo_count), 64'd8);
        chk_dr("fill");
        for (int i = 0; i < 8; i++) pop_one("drain1");
        for (int i = 9; i <= 11; i++) begin
            cap(2'(i - 1), 32'(i), 16'(16'h0100 + i), 1'b0);
        end
        chk("wrap_count", 64'(fifo_count), 64'd3);
        for (int i = 0; i < 3; i++) pop_one("drain2");
        chk("wrap_empty", 64'(fifo_count), 64'd0);

        // Full with simultaneous push and pop
        do_reset();
        for (int i = 1; i <= 8; i++) begin
            cap(2'(i - 1), 32'(20 + i), 16'(16'h0200 + i), 1'b0);
        end
        cap(2'd0, 32'd77, 16'h0300, 1'b1);
        chk("pp_count", 64'(fifo_count), 64'd8);
        chk("pp_ovf", 64'(ovf), 64'(m_ovf));
        chk_dr("pp");
        for (int i = 0; i < 8; i++) pop_one("pp_drain");
        chk("pp_empty", 64'(fifo_count), 64'd0);

`ifndef DBG_CAPTURE_STALL_EN
        // Overflow drops
        for (int i = 1; i <= 8; i++) begin
            cap(2'(i - 1), 32'(i), 16'(16'h0400 + i), 1'b0);
        end
        cap(2'd1, 32'd99, 16'h0500, 1'b0);
        chk_dr("ovf");
        chk("ovf_count", 64'(fifo_count), 64'd8);
        chk("ovf_flag", 64'(ovf), 64'd1);
        chk("ovf_cnt1", 64'(ovf_cnt), 64'd1);
        chk("ovf_head", 64'(out_data), 64'd1);
        chk("ovf_stall", 64'(stall), 64'd0);
        for (int i = 0; i < 300; i++) begin
            cap(2'(i), 32'(1000 + i), 16'h0600, 1'b0);
        end
        chk("ovf_cnt_sat", 64'(ovf_cnt), 64'(m_ovf_cnt));
        chk("ovf_cnt_255", 64'(ovf_cnt), 64'd255);
        chk_dr("ovf_sat");
        for (int i = 0; i < 8; i++) pop_one("ovf_drain");
        chk("ovf_sticky", 64'(ovf), 64'd1);
`else
        // Back-pressure: held capture is not dropped
        for (int i = 1; i <= 8; i++) begin
            cap(2'(i - 1), 32'(i), 16'(16'h0400 + i), 1'b0);
        end
        instr_op  = 8'hD3;
        cur_state = 4'd1;
        ch_sel    = 2'd1;
        cap_data  = 32'd55;
        pc        = 16'h0700;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("stall_hi", 64'(stall), 64'd1);
            step();
            chk("stall_count", 64'(fifo_count), 64'd8);
            chk("stall_ovf_cnt", 64'(ovf_cnt), 64'd0);
            chk("stall_ovf", 64'(ovf), 64'd0);
            chk_dr("stall");
        end
        idle();
        cap(2'd1, 32'd55, 16'h0700, 1'b1);
        chk("stall_acc_count", 64'(fifo_count), 64'd8);
        chk("stall_released", 64'(stall), 64'd1);
        chk_dr("stall_acc");
        chk("stall_acc_ovf_cnt", 64'(ovf_cnt), 64'd0);
`endif

        // Asynchronous reset while out_valid is high
        do_reset();
        for (int i = 1; i <= 4; i++) begin
            cap(2'(i - 1), 32'(40 + i), 16'h0800, 1'b0);
        end
        chk("arst_pre_valid", 64'(out_valid), 64'd1);
        #2;
        reset = 1'b0;
        model_clear();
        #1;
        chk("arst_valid", 64'(out_valid), 64'd0);
        chk("arst_count", 64'(fifo_count), 64'd0);
        chk("arst_ovf_cnt", 64'(ovf_cnt), 64'd0);
        chk_dr("arst");
        step();
        reset = 1'b1;
        step();
        chk("arst_post_count", 64'(fifo_count), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
